// File: rtl/ws2812_rx.sv
// WS2812 strand receiver: measures high-pulse widths, assembles GRB words
// MSB-first, emits one indexed pixel per word and reports frame end at the
// latch gap. Glitches and stuck-high pulses abandon the frame until the line
// has been quiet for a full latch gap.
module ws2812_rx #(
  parameter int NUM_LEDS     = 10,
  parameter int COLOR_WIDTH  = 8,
  parameter int BIT_THRESH   = 60,
  parameter int MIN_HIGH     = 20,
  parameter int MAX_HIGH     = 110,
  parameter int RESET_CYCLES = 5000
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            strand_in,
  output logic                            pixel_valid,
  output logic [$clog2(NUM_LEDS)-1:0]     led_index,
  output logic [COLOR_WIDTH-1:0]          green_out,
  output logic [COLOR_WIDTH-1:0]          red_out,
  output logic [COLOR_WIDTH-1:0]          blue_out,
  output logic                            frame_done,
  output logic [$clog2(NUM_LEDS+1)-1:0]   pixel_count,
  output logic                            frame_error,
  output logic                            bit_error
);

  localparam int WORD_W = 3 * COLOR_WIDTH;
  localparam int IDX_W  = $clog2(NUM_LEDS);
  localparam int PC_W   = $clog2(NUM_LEDS + 1);
  localparam int HC_W   = $clog2(MAX_HIGH + 1);
  localparam int LC_W   = $clog2(RESET_CYCLES + 1);
  localparam int BC_W   = $clog2(WORD_W);

  localparam logic [HC_W-1:0] HC_MIN  = HC_W'(MIN_HIGH);
  localparam logic [HC_W-1:0] HC_THR  = HC_W'(BIT_THRESH);
  localparam logic [HC_W-1:0] HC_MAX  = HC_W'(MAX_HIGH);
  localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);
  localparam logic [LC_W-1:0] LC_GAP  = LC_W'(RESET_CYCLES);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
  localparam logic [PC_W-1:0] PC_MAX  = PC_W'(NUM_LEDS);

  typedef enum logic [1:0] {S_HUNT, S_IDLE, S_HIGH, S_LOW} state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_sync1, r_sync2, r_prev;
  logic               w_rise, w_fall;
  logic               w_load_high, w_shift, w_abort, w_gap;
  logic [HC_W-1:0]    r_high_cnt;
  logic [LC_W-1:0]    r_low_cnt;
  logic [LC_W-1:0]    w_low_inc;
  logic [BC_W-1:0]    r_bit_cnt;
  logic [WORD_W-1:0]  r_shift;
  logic [PC_W-1:0]    r_pixels_rx;
  logic               r_overflow;
  logic               r_word_rdy;

  assign w_rise    = r_sync2 & ~r_prev;
  assign w_fall    = ~r_sync2 & r_prev;
  assign w_low_inc = (r_low_cnt == LC_GAP) ? r_low_cnt : r_low_cnt + 1'b1;

  // Two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= strand_in;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= S_HUNT;
    else        r_state <= w_next;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    w_next      = r_state;
    w_load_high = 1'b0;
    w_shift     = 1'b0;
    w_abort     = 1'b0;
    w_gap       = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (!r_sync2 && r_low_cnt == LC_GAP) w_next = S_IDLE;
      end
      S_IDLE: begin
        if (w_rise) begin
          w_load_high = 1'b1;
          w_next      = S_HIGH;
        end
      end
      S_HIGH: begin
        if (r_high_cnt == HC_MAX) begin
          w_abort = 1'b1;
          w_next  = S_HUNT;
        end else if (w_fall) begin
          if (r_high_cnt < HC_MIN) begin
            w_abort = 1'b1;
            w_next  = S_HUNT;
          end else begin
            w_shift = 1'b1;
            w_next  = S_LOW;
          end
        end
      end
      S_LOW: begin
        if (w_rise) begin
          w_load_high = 1'b1;
          w_next      = S_HIGH;
        end else if (r_low_cnt == LC_GAP) begin
          w_gap  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_HUNT;
    endcase
  end

  // Pulse-width counters; the rise cycle itself counts, so high_cnt equals
  // the synchronized high width when the falling edge is seen
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_high_cnt <= '0;
      r_low_cnt  <= '0;
    end else begin
      if (w_load_high)
        r_high_cnt <= HC_ONE;
      else if (r_state == S_HIGH && r_sync2 && r_high_cnt != HC_MAX)
        r_high_cnt <= r_high_cnt + 1'b1;

      if (w_abort || w_shift)  r_low_cnt <= '0;
      else if (r_state == S_HUNT) r_low_cnt <= r_sync2 ? '0 : w_low_inc;
      else if (r_state == S_LOW)  r_low_cnt <= w_low_inc;
    end
  end

  // Word assembly and per-frame bookkeeping
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_pixels_rx <= '0;
      r_overflow  <= 1'b0;
      r_word_rdy  <= 1'b0;
    end else begin
      r_word_rdy <= 1'b0;
      if (r_word_rdy) begin
        if (r_pixels_rx < PC_MAX) r_pixels_rx <= r_pixels_rx + 1'b1;
        else                      r_overflow  <= 1'b1;
      end
      if (w_abort || w_gap) begin
        r_bit_cnt   <= '0;
        r_pixels_rx <= '0;
        r_overflow  <= 1'b0;
      end else if (w_shift) begin
        r_shift <= {r_shift[WORD_W-2:0], (r_high_cnt >= HC_THR)};
        if (r_bit_cnt == BC_LAST) begin
          r_bit_cnt  <= '0;
          r_word_rdy <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end
    end
  end

  // Registered outputs: strobes default low, pixel data holds between strobes
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pixel_valid <= 1'b0;
      led_index   <= '0;
      green_out   <= '0;
      red_out     <= '0;
      blue_out    <= '0;
      frame_done  <= 1'b0;
      pixel_count <= '0;
      frame_error <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      frame_error <= 1'b0;
      bit_error   <= w_abort;
      if (r_word_rdy && r_pixels_rx < PC_MAX) begin
        pixel_valid <= 1'b1;
        led_index   <= IDX_W'(r_pixels_rx);
        green_out   <= r_shift[WORD_W-1:2*COLOR_WIDTH];
        red_out     <= r_shift[2*COLOR_WIDTH-1:COLOR_WIDTH];
        blue_out    <= r_shift[COLOR_WIDTH-1:0];
      end
      if (w_gap) begin
        frame_done  <= 1'b1;
        pixel_count <= r_pixels_rx;
        frame_error <= (r_bit_cnt != '0) || r_overflow;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_rx.sv
// Randomized bench for ws2812_rx: drives pulse trains, predicts pixels and
// frame results from the pulse widths, and compares what the receiver reports.
`timescale 1ns/1ps
module tb_ws2812_rx;
  localparam int NUM_LEDS     = 10;
  localparam int COLOR_WIDTH  = 8;
  localparam int BIT_THRESH   = 60;
  localparam int MIN_HIGH     = 20;
  localparam int MAX_HIGH     = 110;
  localparam int RESET_CYCLES = 1200;
  localparam int GAP_HOLD     = RESET_CYCLES + 100;

  logic clk = 1'b0, rst = 1'b0, strand = 1'b0;
  logic pv, fd, fe, be;
  logic [3:0] idx, pc;
  logic [7:0] g, r, b;

  ws2812_rx #(.NUM_LEDS(NUM_LEDS), .COLOR_WIDTH(COLOR_WIDTH), .BIT_THRESH(BIT_THRESH),
              .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH), .RESET_CYCLES(RESET_CYCLES))
    dut (.clk_in(clk), .rst_in(rst), .strand_in(strand), .pixel_valid(pv),
         .led_index(idx), .green_out(g), .red_out(r), .blue_out(b), .frame_done(fd),
         .pixel_count(pc), .frame_error(fe), .bit_error(be));

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] idx; logic [7:0] g, r, b; logic [31:0] cyc; } pix_t;
  typedef struct packed { logic [3:0] cnt; logic err; } frm_t;

  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   n_berr = 0;
  pix_t got_pix[$], exp_pix[$];
  frm_t got_frm[$], exp_frm;
  int   wq[$], falls[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst) begin
      if (pv) got_pix.push_back({idx, g, r, b, cyc});
      if (fd) got_frm.push_back({pc, fe});
      if (be) n_berr++;
    end
  end

  task automatic hold(input logic lvl, input int n);
    strand = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    got_pix.delete(); got_frm.delete(); n_berr = 0;
    wq.delete(); falls.delete();
  endtask

  function automatic int rand_w(input logic one);
    return one ? 62 + int'($urandom_range(0, 28)) : 22 + int'($urandom_range(0, 18));
  endfunction

  task automatic add_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) wq.push_back(rand_w(w[i]));
  endtask

  // period > 0 gives fixed bit period; otherwise a short random low time
  task automatic send_wq(input int period);
    foreach (wq[i]) begin
      hold(1'b1, wq[i]);
      falls.push_back(cyc);
      hold(1'b0, (period > 0) ? period - wq[i] : 6 + int'($urandom_range(0, 6)));
    end
  endtask

  // Reference: decode widths by threshold, group into 24-bit words, keep the
  // first NUM_LEDS; pixel appears 4 cycles after the low level is driven
  task automatic model();
    int words;
    logic [23:0] wd;
    words = wq.size() / 24;
    exp_pix.delete();
    for (int k = 0; k < words && k < NUM_LEDS; k++) begin
      wd = '0;
      for (int i = 0; i < 24; i++) wd = {wd[22:0], (wq[k*24+i] >= BIT_THRESH)};
      exp_pix.push_back({4'(k), wd[23:16], wd[15:8], wd[7:0], 32'(falls[k*24+23] + 4)});
    end
    exp_frm.cnt = 4'((words < NUM_LEDS) ? words : NUM_LEDS);
    exp_frm.err = ((wq.size() % 24) != 0) || (words > NUM_LEDS);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    hold(1'b0, 3);
    checks++;
    if ({pv, idx, g, r, b, fd, pc, fe, be} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h exp 0", {pv, idx, g, r, b, fd, pc, fe, be});
    end
    rst = 1'b0;
    clr();
    hold(1'b0, GAP_HOLD);
    checks++;
    if (got_frm.size() != 0 || n_berr != 0 || got_pix.size() != 0) begin
      errors++; $display("FAIL hunt_quiet got frames %0d berr %0d exp 0 0", got_frm.size(), n_berr);
    end
  endtask

  task automatic test_single_word();
    clr();
    for (int i = 23; i >= 0; i--) wq.push_back(logic'((24'hFF00A5 >> i) & 1) ? 80 : 40);
    send_wq(125);
    hold(1'b0, GAP_HOLD);
    model();
    checks++;
    if (got_pix.size() != 1) begin
      errors++; $display("FAIL single_npix got %0d exp 1", got_pix.size());
    end else begin
      checks++;
      if (got_pix[0] !== exp_pix[0] || got_pix[0].g !== 8'hFF || got_pix[0].b !== 8'hA5) begin
        errors++; $display("FAIL single_pix got %h exp %h", got_pix[0], exp_pix[0]);
      end
    end
    checks++;
    if (got_frm.size() != 1 || got_frm[0] !== 5'b0001_0 || n_berr != 0) begin
      errors++; $display("FAIL single_frame got n %0d berr %0d exp 1 frame cnt 1 err 0", got_frm.size(), n_berr);
    end
  endtask

  // words == NUM_LEDS for the full loopback frame, NUM_LEDS+1 for overflow
  task automatic test_frame(input int words, input int bits_extra);
    clr();
    for (int k = 0; k < words; k++)
      add_word((words == NUM_LEDS) ? {8'(k), 8'(2*k), 8'(255-k)} : 24'($urandom));
    for (int i = 0; i < bits_extra; i++) wq.push_back(rand_w(logic'($urandom_range(0, 1))));
    send_wq(0);
    hold(1'b0, GAP_HOLD);
    model();
    checks++;
    if (got_pix.size() != exp_pix.size()) begin
      errors++; $display("FAIL frame%0d_npix got %0d exp %0d", words, got_pix.size(), exp_pix.size());
    end
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++) begin
      checks++;
      if (got_pix[i] !== exp_pix[i]) begin
        errors++; $display("FAIL frame%0d_pix%0d got %h exp %h", words, i, got_pix[i], exp_pix[i]);
      end
    end
    checks++;
    if (got_frm.size() != 1) begin
      errors++; $display("FAIL frame%0d_nframes got %0d exp 1", words, got_frm.size());
    end else begin
      checks++;
      if (got_frm[0] !== exp_frm) begin
        errors++; $display("FAIL frame%0d_result got %h exp %h", words, got_frm[0], exp_frm);
      end
    end
    checks++;
    if (n_berr != 0) begin
      errors++; $display("FAIL frame%0d_berr got %0d exp 0", words, n_berr);
    end
  endtask

  task automatic test_thresholds();
    int wv[4];
    wv = '{MIN_HIGH, BIT_THRESH - 1, BIT_THRESH, MAX_HIGH - 1};
    clr();
    for (int i = 0; i < 24; i++) wq.push_back(wv[(i < 4) ? i : int'($urandom_range(0, 3))]);
    send_wq(0);
    hold(1'b0, GAP_HOLD);
    model();
    checks++;
    if (got_pix.size() != 1 || got_frm.size() != 1) begin
      errors++; $display("FAIL thresh_counts got pix %0d frm %0d exp 1 1", got_pix.size(), got_frm.size());
    end else begin
      checks++;
      if (got_pix[0] !== exp_pix[0] || got_frm[0] !== exp_frm) begin
        errors++; $display("FAIL thresh_word got %h/%h exp %h/%h", got_pix[0], got_frm[0], exp_pix[0], exp_frm);
      end
    end
    for (int t = 0; t < 2; t++) begin
      clr();
      hold(1'b1, (t == 0) ? MIN_HIGH - 1 : MAX_HIGH);
      hold(1'b0, GAP_HOLD);
      checks++;
      if (n_berr != 1 || got_frm.size() != 0 || got_pix.size() != 0) begin
        errors++; $display("FAIL thresh_err%0d got berr %0d frm %0d exp 1 0", t, n_berr, got_frm.size());
      end
    end
  endtask

  task automatic test_glitch();
    clr();
    for (int i = 0; i < 10; i++) wq.push_back(rand_w(logic'($urandom_range(0, 1))));
    send_wq(0);
    hold(1'b1, 5);
    hold(1'b0, 10);
    wq.delete();
    add_word(24'($urandom)); add_word(24'($urandom));
    send_wq(0);
    hold(1'b0, GAP_HOLD);
    checks++;
    if (n_berr != 1 || got_pix.size() != 0 || got_frm.size() != 0) begin
      errors++; $display("FAIL glitch_drop got berr %0d pix %0d frm %0d exp 1 0 0", n_berr, got_pix.size(), got_frm.size());
    end
    test_frame(2, 0);
  endtask

  task automatic test_reset_mid();
    logic [23:0] w;
    clr();
    w = 24'($urandom);
    for (int i = 23; i >= 18; i--) wq.push_back(rand_w(w[i]));
    send_wq(0);
    hold(1'b1, 20);
    rst = 1'b1;
    hold(1'b1, 2);
    checks++;
    if ({pv, idx, g, r, b, fd, pc, fe, be} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got %h exp 0", {pv, idx, g, r, b, fd, pc, fe, be});
    end
    rst = 1'b0;
    hold(1'b1, 40);
    hold(1'b0, 10);
    clr();
    add_word(24'($urandom));
    send_wq(0);
    hold(1'b0, GAP_HOLD);
    checks++;
    if (got_pix.size() != 0 || got_frm.size() != 0 || n_berr != 0) begin
      errors++; $display("FAIL rstmid_ignored got pix %0d frm %0d berr %0d exp 0 0 0", got_pix.size(), got_frm.size(), n_berr);
    end
    test_frame(1, 0);
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_single_word();
    test_frame(NUM_LEDS, 0);
    test_frame(NUM_LEDS + 1, 0);
    test_frame(0, 12);
    test_thresholds();
    test_glitch();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
